// File: rtl/pattern_match_stream.sv
// Streaming bit-pattern matcher with programmable pattern/mask, cross-word
// matching, overlap / non-overlap modes and a saturating hit counter.
module pattern_match_stream #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned PAT_MAX   = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         clear,
  input  logic                         cfg_we,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [PAT_MAX-1:0]           cfg_mask,
  input  logic                         cfg_nonovl,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_SIZE-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_SIZE-1:0]         out_data,
  output logic [DATA_SIZE-1:0]         out_hits,
  output logic                         out_match,
  output logic [$clog2(DATA_SIZE)-1:0] out_first,
  output logic [CNT_W-1:0]             hit_total
);

  localparam int unsigned FIRST_W = $clog2(DATA_SIZE);
  localparam int unsigned HIST_W  = PAT_MAX - 1;
  localparam int unsigned EXT_W   = DATA_SIZE + HIST_W;
  localparam int unsigned SEEN_W  = $clog2(PAT_MAX);
  localparam int unsigned POP_W   = $clog2(DATA_SIZE + 1);
  localparam int unsigned SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [HIST_W-1:0]    hist;
  logic [SEEN_W-1:0]    seen;
  logic [SEEN_W-1:0]    skip;
  logic [PAT_MAX-1:0]   pattern;
  logic [PAT_MAX-1:0]   mask;
  logic                 nonovl;

  logic                 accept;
  logic                 restart;
  logic [EXT_W-1:0]     ext;
  logic [PAT_MAX-1:0]   win;
  logic [DATA_SIZE-1:0] qual;
  logic [DATA_SIZE-1:0] hits_c;
  logic [SEEN_W-1:0]    s;
  logic [SEEN_W-1:0]    skip_nxt;
  logic [POP_W-1:0]     pop;
  logic [FIRST_W-1:0]   first_c;
  logic                 found;
  logic [SUM_W-1:0]     sum;
  logic [CNT_W-1:0]     total_nxt;

  // Handshake: a restart cycle never accepts a word
  assign in_ready = (!out_valid || out_ready) && !cfg_we && !clear;
  assign accept   = in_valid && in_ready;
  assign restart  = cfg_we || clear;

  // Window compare, start-of-stream qualification and match-mode selection
  always_comb begin
    ext      = {in_data, hist};
    win      = '0;
    qual     = '0;
    hits_c   = '0;
    s        = skip;
    skip_nxt = '0;
    for (int unsigned j = 0; j < DATA_SIZE; j++) begin
      win = ext[j +: PAT_MAX];
      if ((((win ^ pattern) & mask) == '0) && ((32'(seen) + j) >= HIST_W)) begin
        qual[j] = 1'b1;
      end
    end
    if (nonovl) begin
      // A hit blocks the next PAT_MAX-1 positions, carried across words
      for (int unsigned j = 0; j < DATA_SIZE; j++) begin
        if (qual[j] && (s == '0)) begin
          hits_c[j] = 1'b1;
          s         = SEEN_W'(HIST_W);
        end else if (s != '0) begin
          s = s - SEEN_W'(1);
        end
      end
      skip_nxt = s;
    end else begin
      hits_c = qual;
    end
  end

  // Hit statistics: popcount, lowest hit index, clamped running total
  always_comb begin
    pop     = '0;
    first_c = '0;
    found   = 1'b0;
    for (int unsigned j = 0; j < DATA_SIZE; j++) begin
      pop = pop + POP_W'(hits_c[j]);
      if (hits_c[j] && !found) begin
        first_c = FIRST_W'(j);
        found   = 1'b1;
      end
    end
    sum = SUM_W'(hit_total) + SUM_W'(pop);
    if (sum > SUM_W'({CNT_W{1'b1}})) begin
      total_nxt = '1;
    end else begin
      total_nxt = CNT_W'(sum);
    end
  end

  // Stream history, seen and skip state; cleared on restart
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hist <= '0;
      seen <= '0;
      skip <= '0;
    end else if (restart) begin
      hist <= '0;
      seen <= '0;
      skip <= '0;
    end else if (accept) begin
      hist <= in_data[DATA_SIZE-1 -: HIST_W];
      seen <= SEEN_W'(HIST_W);
      skip <= skip_nxt;
    end
  end

  // Runtime configuration registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pattern <= '0;
      mask    <= '0;
      nonovl  <= 1'b0;
    end else if (cfg_we) begin
      pattern <= cfg_pattern;
      mask    <= cfg_mask;
      nonovl  <= cfg_nonovl;
    end
  end

  // Output word registers and valid handshake
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hits  <= '0;
      out_match <= 1'b0;
      out_first <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_hits  <= hits_c;
      out_match <= |hits_c;
      out_first <= first_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating hit counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hit_total <= '0;
    end else if (clear) begin
      hit_total <= '0;
    end else if (accept) begin
      hit_total <= total_nxt;
    end
  end

endmodule
